// File: rtl/t05_hist_pkg.sv
// Shared types and defaults for the histogram stage of the Huffman compressor.
package t05_hist_pkg;

  localparam int unsigned CHAR_W_DEF = 8;
  localparam int unsigned CNT_W_DEF  = 32;
  localparam int unsigned NUM_BINS   = 256;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_CLEAR     = 3'd1,
    S_WAIT_CHAR = 3'd2,
    S_RD_REQ    = 3'd3,
    S_WR_REQ    = 3'd4,
    S_DONE      = 3'd5
  } hist_state_t;

endpackage

// File: rtl/t05_sat_inc.sv
// Combinational saturating increment: value+1, clamped at all-ones.
module t05_sat_inc #(
  parameter int unsigned W = 32
) (
  input  logic [W-1:0] i_value,
  output logic [W-1:0] o_value
);

  assign o_value = (&i_value) ? i_value : i_value + W'(1);

endmodule

// File: rtl/t05_histogram.sv
// Histogram builder: counts input bytes into 2**CHAR_W SRAM bins using a
// read-modify-write over a req/ack word port, then reports the total.
// Optional macro HIST_BYPASS_EN adds a one-entry cache of the last written
// bin so a repeated byte skips the SRAM read.
module t05_histogram
  import t05_hist_pkg::*;
#(
  parameter int unsigned CHAR_W         = CHAR_W_DEF,
  parameter int unsigned CNT_W          = CNT_W_DEF,
  parameter int unsigned CLEAR_ON_START = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [CHAR_W-1:0] in_char,
  output logic              in_ready,
  input  logic              eof,
  output logic              mem_req,
  output logic              mem_wr,
  output logic [CHAR_W-1:0] mem_addr,
  output logic [CNT_W-1:0]  mem_wdata,
  input  logic [CNT_W-1:0]  mem_rdata,
  input  logic              mem_ack,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  total_chars
);

  localparam logic [CHAR_W:0] LAST_IDX = {1'b0, {CHAR_W{1'b1}}};

  hist_state_t       r_state;
  logic [CHAR_W:0]   r_clr_idx;
  logic [CNT_W-1:0]  r_total;
  logic              r_mem_req;
  logic              r_mem_wr;
  logic [CHAR_W-1:0] r_mem_addr;
  logic [CNT_W-1:0]  r_mem_wdata;
  logic              r_done;

  logic [CNT_W-1:0]  w_bin_src;
  logic [CNT_W-1:0]  w_bin_inc;
  logic [CNT_W-1:0]  w_total_inc;

`ifdef HIST_BYPASS_EN
  logic [CHAR_W-1:0] r_last_char;
  logic [CNT_W-1:0]  r_last_count;
  logic              r_last_valid;
  logic              w_hit;

  assign w_hit     = r_last_valid && (r_last_char == in_char);
  // Outside RD_REQ the incrementer only matters for a cache hit in WAIT_CHAR.
  assign w_bin_src = (r_state == S_RD_REQ) ? mem_rdata : r_last_count;
`else
  assign w_bin_src = mem_rdata;
`endif

  t05_sat_inc #(.W(CNT_W)) u_bin_inc (
    .i_value (w_bin_src),
    .o_value (w_bin_inc)
  );

  t05_sat_inc #(.W(CNT_W)) u_total_inc (
    .i_value (r_total),
    .o_value (w_total_inc)
  );

  assign in_ready    = (r_state == S_WAIT_CHAR);
  assign busy        = (r_state != S_IDLE);
  assign done        = r_done;
  assign total_chars = r_total;
  assign mem_req     = r_mem_req;
  assign mem_wr      = r_mem_wr;
  assign mem_addr    = r_mem_addr;
  assign mem_wdata   = r_mem_wdata;

  // Pass sequencing, registered SRAM request and counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_clr_idx   <= '0;
      r_total     <= '0;
      r_mem_req   <= 1'b0;
      r_mem_wr    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_done      <= 1'b0;
`ifdef HIST_BYPASS_EN
      r_last_char  <= '0;
      r_last_count <= '0;
      r_last_valid <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_total   <= '0;
            r_clr_idx <= '0;
`ifdef HIST_BYPASS_EN
            r_last_valid <= 1'b0;
`endif
            if (CLEAR_ON_START != 0) r_state <= S_CLEAR;
            else                     r_state <= S_WAIT_CHAR;
          end
        end

        // One idle cycle between clear writes keeps mem_req dropping after each ack.
        S_CLEAR: begin
          if (!r_mem_req) begin
            r_mem_req   <= 1'b1;
            r_mem_wr    <= 1'b1;
            r_mem_addr  <= r_clr_idx[CHAR_W-1:0];
            r_mem_wdata <= '0;
`ifdef HIST_BYPASS_EN
            r_last_valid <= 1'b0;
`endif
          end else if (mem_ack) begin
            r_mem_req <= 1'b0;
            r_mem_wr  <= 1'b0;
            r_clr_idx <= r_clr_idx + {{CHAR_W{1'b0}}, 1'b1};
            if (r_clr_idx == LAST_IDX) r_state <= S_WAIT_CHAR;
          end
        end

        // mem_addr doubles as the latched character for the whole update.
        S_WAIT_CHAR: begin
          if (in_valid) begin
            r_mem_addr <= in_char;
            r_mem_req  <= 1'b1;
`ifdef HIST_BYPASS_EN
            if (w_hit) begin
              r_mem_wr    <= 1'b1;
              r_mem_wdata <= w_bin_inc;
              r_state     <= S_WR_REQ;
            end else begin
              r_mem_wr <= 1'b0;
              r_state  <= S_RD_REQ;
            end
`else
            r_mem_wr <= 1'b0;
            r_state  <= S_RD_REQ;
`endif
          end else if (eof) begin
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end
        end

        // The write request follows the read ack directly; req stays high.
        S_RD_REQ: begin
          if (mem_ack) begin
            r_mem_wr    <= 1'b1;
            r_mem_wdata <= w_bin_inc;
            r_state     <= S_WR_REQ;
          end
        end

        S_WR_REQ: begin
          if (mem_ack) begin
            r_mem_req <= 1'b0;
            r_mem_wr  <= 1'b0;
            r_total   <= w_total_inc;
`ifdef HIST_BYPASS_EN
            r_last_char  <= r_mem_addr;
            r_last_count <= r_mem_wdata;
            r_last_valid <= 1'b1;
`endif
            r_state <= S_WAIT_CHAR;
          end
        end

        S_DONE: begin
          r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_t05_histogram.sv
// Self-checking bench for t05_histogram with a behavioural SRAM responder.
module tb_t05_histogram;

`ifdef HIST_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        in_valid;
  logic [7:0]  in_char;
  logic        in_ready;
  logic        eof;
  logic        mem_req;
  logic        mem_wr;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;
  logic        busy;
  logic        done;
  logic [31:0] total_chars;

  t05_histogram #(.CHAR_W(8), .CNT_W(32), .CLEAR_ON_START(1)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_char(in_char),
    .in_ready(in_ready), .eof(eof), .mem_req(mem_req), .mem_wr(mem_wr),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack), .busy(busy), .done(done), .total_chars(total_chars)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // SRAM model: acks a request after it has been seen for 1+ack_delay negedges.
  logic [31:0] mem [256];
  int ack_delay = 0;
  int rcnt = 0;
  int pend = 0;
  logic [7:0]  wl_addr [$];
  logic [31:0] wl_data [$];

  always @(negedge clk) begin
    if (rst) begin
      mem_ack = 1'b0;
      pend = 0;
    end else if (mem_ack) begin
      mem_ack = 1'b0;
      pend = mem_req ? 1 : 0;
    end else if (mem_req) begin
      if (pend >= 1 + ack_delay) begin
        mem_ack = 1'b1;
        if (mem_wr) begin
          mem[mem_addr] = mem_wdata;
          wl_addr.push_back(mem_addr);
          wl_data.push_back(mem_wdata);
        end else begin
          mem_rdata = mem[mem_addr];
          rcnt++;
        end
      end else begin
        pend++;
      end
    end else begin
      pend = 0;
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input int budget);
    int n;
    n = 0;
    while (!in_ready && n < budget) begin
      tick();
      n++;
    end
    chk("ready_timeout", {31'b0, in_ready}, 32'd1);
  endtask

  task automatic send_char(input logic [7:0] c, output int acc);
    wait_ready(50);
    in_valid = 1'b1;
    in_char  = c;
    tick();
    acc = cyc;
    in_valid = 1'b0;
  endtask

  task automatic start_pass();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  typedef struct {
    logic [7:0]  ch;
    bit          pre_en;
    logic [31:0] pre;
    logic [31:0] exp_wdata;
    logic [31:0] exp_total;
  } vec_t;

  vec_t tab [7];

  initial begin
    int acc, gap, r0, n0, bad, n;
    int accs [3];
    bit hit;

    tab[0] = '{8'h41, 1'b0, 32'h0,         32'd1,         32'd1};
    tab[1] = '{8'h42, 1'b0, 32'h0,         32'd1,         32'd2};
    tab[2] = '{8'h41, 1'b0, 32'h0,         32'd2,         32'd3};
    tab[3] = '{8'h7F, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd4};
    tab[4] = '{8'h00, 1'b0, 32'h0,         32'd1,         32'd5};
    tab[5] = '{8'hFF, 1'b0, 32'h0,         32'd1,         32'd6};
    tab[6] = '{8'hFF, 1'b0, 32'h0,         32'd2,         32'd7};

    for (int i = 0; i < 256; i++) mem[i] = 32'hA5A5_0000 + 32'(i);
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_char = '0; eof = 1'b0;
    repeat (3) tick();
    chk("rst_in_ready", {31'b0, in_ready}, 0);
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_done", {31'b0, done}, 0);
    chk("rst_mem_req", {31'b0, mem_req}, 0);
    chk("rst_mem_wr", {31'b0, mem_wr}, 0);
    chk("rst_mem_addr", {24'b0, mem_addr}, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_total", total_chars, 0);
    rst = 1'b0;
    tick();

    // Clear pass: 256 zero writes in ascending order, no wrap.
    r0 = rcnt;
    start_pass();
    chk("start_busy", {31'b0, busy}, 1);
    chk("start_not_ready", {31'b0, in_ready}, 0);
    wait_ready(3000);
    chk("clear_writes", wl_addr.size(), 256);
    bad = 0;
    for (int i = 0; i < wl_addr.size(); i++)
      if (wl_addr[i] != 8'(i) || wl_data[i] != 32'd0) bad++;
    chk("clear_order", bad, 0);
    chk("clear_reads", rcnt - r0, 0);
    repeat (4) tick();
    chk("clear_no_wrap", wl_addr.size(), 256);
    chk("wait_busy", {31'b0, busy}, 1);

    // Table-driven counting pass; accept-to-ready is 5 cycles (4 edges), 3 on a cache hit.
    for (int i = 0; i < 7; i++) begin
      if (tab[i].pre_en) mem[tab[i].ch] = tab[i].pre;
      hit = BYP && (i > 0) && (tab[i-1].ch == tab[i].ch);
      r0 = rcnt;
      n0 = wl_addr.size();
      send_char(tab[i].ch, acc);
      wait_ready(50);
      gap = cyc - acc;
      chk($sformatf("v%0d_reads", i), rcnt - r0, hit ? 0 : 1);
      chk($sformatf("v%0d_nwrites", i), wl_addr.size() - n0, 1);
      chk($sformatf("v%0d_addr", i), {24'b0, wl_addr[wl_addr.size()-1]}, {24'b0, tab[i].ch});
      chk($sformatf("v%0d_wdata", i), wl_data[wl_data.size()-1], tab[i].exp_wdata);
      chk($sformatf("v%0d_total", i), total_chars, tab[i].exp_total);
      chk($sformatf("v%0d_latency", i), gap, hit ? 2 : 4);
    end
    chk("bin41", mem[8'h41], 2);
    chk("bin42", mem[8'h42], 1);
    chk("bin7f_sat", mem[8'h7F], 32'hFFFF_FFFF);
    eof = 1'b1;
    n = 0;
    while (!done && n < 10) begin tick(); n++; end
    chk("done_seen", {31'b0, done}, 1);
    chk("done_total", total_chars, 7);
    tick();
    chk("done_one_cycle", {31'b0, done}, 0);
    chk("done_idle", {31'b0, busy}, 0);
    eof = 1'b0;
    repeat (3) tick();
    chk("total_held", total_chars, 7);

    // in_valid and eof together: the byte is counted before DONE.
    start_pass();
    wait_ready(3000);
    in_valid = 1'b1; in_char = 8'h10; eof = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("eofv_no_done", {31'b0, done}, 0);
    chk("eofv_rd", {31'b0, in_ready}, 0);
    wait_ready(50);
    chk("eofv_total", total_chars, 1);
    chk("eofv_wdata", wl_data[wl_data.size()-1], 1);
    tick();
    chk("eofv_done", {31'b0, done}, 1);
    eof = 1'b0;
    tick();

    // Empty file.
    start_pass();
    wait_ready(3000);
    r0 = rcnt;
    n0 = wl_addr.size();
    eof = 1'b1;
    tick();
    chk("empty_done", {31'b0, done}, 1);
    chk("empty_total", total_chars, 0);
    tick();
    chk("empty_done_pulse", {31'b0, done}, 0);
    eof = 1'b0;
    chk("empty_no_rd", rcnt - r0, 0);
    chk("empty_no_wr", wl_addr.size() - n0, 0);

    // start while busy is ignored; delayed read ack; reset mid-RD_REQ.
    start_pass();
    wait_ready(3000);
    send_char(8'h33, acc);
    wait_ready(50);
    chk("p4_total", total_chars, 1);
    start_pass();
    chk("start_ignored_ready", {31'b0, in_ready}, 1);
    chk("start_ignored_total", total_chars, 1);
    ack_delay = 5;
    r0 = rcnt;
    send_char(8'h55, acc);
    bad = 0;
    for (int k = 0; k < 5; k++) begin
      if (mem_req !== 1'b1 || mem_addr !== 8'h55 || mem_wr !== 1'b0 || in_ready !== 1'b0) bad++;
      tick();
    end
    chk("delay_stable", bad, 0);
    chk("delay_no_ack", rcnt - r0, 0);
    rst = 1'b1;
    #1;
    chk("arst_mem_req", {31'b0, mem_req}, 0);
    chk("arst_busy", {31'b0, busy}, 0);
    chk("arst_total", total_chars, 0);
    tick();
    rst = 1'b0;
    ack_delay = 0;
    tick();
    start_pass();
    wait_ready(3000);
    send_char(8'h55, acc);
    wait_ready(50);
    chk("recover_wdata", wl_data[wl_data.size()-1], 1);

    // Repeated byte: 5 edges between accepts normally, 3 with the cache.
    r0 = rcnt;
    n0 = wl_addr.size();
    for (int k = 0; k < 3; k++) send_char(8'h20, accs[k]);
    wait_ready(50);
    chk("rep_reads", rcnt - r0, BYP ? 1 : 3);
    chk("rep_nwrites", wl_addr.size() - n0, 3);
    for (int k = 0; k < 3; k++)
      if (wl_addr.size() >= n0 + 3)
        chk($sformatf("rep_wdata%0d", k), wl_data[n0 + k], 32'(k + 1));
    chk("rep_gap1", accs[1] - accs[0], BYP ? 3 : 5);
    chk("rep_gap2", accs[2] - accs[1], BYP ? 3 : 5);
    chk("rep_total", total_chars, 4);
    eof = 1'b1;
    n = 0;
    while (!done && n < 10) begin tick(); n++; end
    chk("rep_done", {31'b0, done}, 1);
    eof = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
